// File: rtl/node_pkg.sv
// Types shared by the router, the links and the local flit ports of one node.
package node_pkg;

  localparam int FLIT_SIZE = 82;

  typedef logic [FLIT_SIZE-1:0] flit_t;

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } issueState_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data; the popped word is valid the
// cycle after the pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_pushData,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_popData,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_popData;
  logic             w_wrEn;
  logic             w_rdEn;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_popData = r_popData;

  // A full FIFO can still take a write when a read frees a slot the same cycle.
  assign w_wrEn = i_push && (!o_full || i_pop);
  assign w_rdEn = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_wrEn) begin
      r_mem[r_wrPtr] <= i_pushData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
      r_popData <= '0;
    end else begin
      if (w_wrEn) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_rdEn) begin
        r_popData <= r_mem[r_rdPtr];
        r_rdPtr   <= r_rdPtr + AW'(1);
      end
      case ({w_wrEn, w_rdEn})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/local_flit_port.sv
// Local endpoint of one router direction: paced injection from a host FIFO,
// registered ejection toward the host, and wrap-around flit counters.
module local_flit_port #(
  parameter int FLIT_SIZE  = node_pkg::FLIT_SIZE,
  parameter int DEPTH      = 8,
  parameter int INJECT_GAP = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [FLIT_SIZE-1:0] host_flit,
  input  logic                 host_valid,
  output logic                 host_ready,
  output logic [FLIT_SIZE-1:0] inject,
  output logic                 inject_valid,
  input  logic [FLIT_SIZE-1:0] eject,
  input  logic                 eject_valid,
  output logic [FLIT_SIZE-1:0] rx_flit,
  output logic                 rx_valid,
  output logic [31:0]          tx_count,
  output logic [31:0]          rx_count
);

  import node_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int GW = $clog2(INJECT_GAP + 2);

  logic                 w_push;
  logic                 w_pop;
  logic                 w_fifoFull;
  logic                 w_fifoEmpty;
  logic [CW-1:0]        w_fifoCount;
  logic [FLIT_SIZE-1:0] w_fifoData;
  logic [CW-1:0]        w_countNext;

  issueState_t          r_state;
  issueState_t          w_stateNext;
  logic [GW-1:0]        r_gapCount;
  logic [GW-1:0]        w_gapNext;

  logic                 r_hostReady;
  logic                 r_popPending;
  logic [FLIT_SIZE-1:0] r_inject;
  logic                 r_injectValid;
  logic [FLIT_SIZE-1:0] r_rxFlit;
  logic                 r_rxValid;
  logic [31:0]          r_txCount;
  logic [31:0]          r_rxCount;

  assign w_push      = host_valid && r_hostReady && !w_fifoFull;
  assign w_countNext = w_fifoCount + CW'(w_push) - CW'(w_pop);

  sync_fifo #(
    .WIDTH (FLIT_SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_pushData (host_flit),
    .i_pop      (w_pop),
    .o_popData  (w_fifoData),
    .o_full     (w_fifoFull),
    .o_empty    (w_fifoEmpty),
    .o_count    (w_fifoCount)
  );

  // The gap counter runs regardless of enable so pacing is never stretched.
  always_comb begin
    w_stateNext = r_state;
    w_gapNext   = r_gapCount;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifoEmpty && enable) begin
          w_pop = 1'b1;
          if (INJECT_GAP > 0) begin
            w_stateNext = GAP;
            w_gapNext   = GW'(INJECT_GAP);
          end
        end
      end
      GAP: begin
        w_gapNext = r_gapCount - GW'(1);
        if (r_gapCount <= GW'(1)) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_gapNext   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gapCount <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_gapCount <= w_gapNext;
    end
  end

  // The popped word arrives from the FIFO one cycle after the pop, so the
  // pending flag lines it up with the inject register load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hostReady   <= 1'b0;
      r_popPending  <= 1'b0;
      r_inject      <= '0;
      r_injectValid <= 1'b0;
      r_rxFlit      <= '0;
      r_rxValid     <= 1'b0;
      r_txCount     <= '0;
      r_rxCount     <= '0;
    end else begin
      r_hostReady   <= (w_countNext < CW'(DEPTH));
      r_popPending  <= w_pop;
      r_injectValid <= r_popPending;
      if (r_popPending) begin
        r_inject  <= w_fifoData;
        r_txCount <= r_txCount + 32'd1;
      end
      r_rxFlit  <= eject;
      r_rxValid <= eject_valid;
      if (eject_valid) begin
        r_rxCount <= r_rxCount + 32'd1;
      end
    end
  end

  assign host_ready   = r_hostReady;
  assign inject       = r_inject;
  assign inject_valid = r_injectValid;
  assign rx_flit      = r_rxFlit;
  assign rx_valid     = r_rxValid;
  assign tx_count     = r_txCount;
  assign rx_count     = r_rxCount;

endmodule

// File: doc/local_flit_port.md
# local_flit_port

Local-side endpoint for one router direction: the transmitter for the router's `inject_*` interface and the receiver for its `eject_*` interface. It buffers host-supplied flits in a FIFO and issues them to the router at a programmable minimum spacing. It registers ejected flits toward the host and keeps wrap-around transmit and receive counters. One instance per direction (xpos, ypos) sits beside the router inside a node.

## Interface
Parameters:
- `FLIT_SIZE`, 82, flit width; opaque to this block.
- `DEPTH`, 8, injection FIFO depth; power of two, at least 2.
- `INJECT_GAP`, 0, minimum number of idle cycles between two consecutive `inject_valid` pulses.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  permits injection; sampled every cycle.
- `host_flit`  in  FLIT_SIZE  flit from host.
- `host_valid`  in  1  host flit valid.
- `host_ready`  out  1  FIFO can accept a flit; registered.
- `inject`  out  FLIT_SIZE  flit to router inject port; registered.
- `inject_valid`  out  1  qualifies `inject` for one cycle; no backpressure.
- `eject`  in  FLIT_SIZE  flit from router eject port.
- `eject_valid`  in  1  qualifies `eject`.
- `rx_flit`  out  FLIT_SIZE  registered copy of `eject`.
- `rx_valid`  out  1  registered copy of `eject_valid`.
- `tx_count`  out  32  number of flits injected; wraps at 2^32.
- `rx_count`  out  32  number of flits ejected; wraps at 2^32.

## Operation
- **Push:** a flit is written when `host_valid && host_ready`.
- **`host_ready` rule:** `host_ready` next = (count_next < DEPTH). A flit written at fill level DEPTH-1 therefore drops `host_ready` on the following cycle.
- **Issue FSM states:** `IDLE`, `GAP`.
- **IDLE pop:** in `IDLE`, when the FIFO is non-empty and `enable` = 1, pop the head. On the next edge, load it into `inject` and set `inject_valid` = 1. If `INJECT_GAP` > 0, go to `GAP`.
- **GAP:** load gap counter = INJECT_GAP. Decrement once per cycle; no pop while counter ≠ 0. Return to `IDLE` when the count reaches 0.
- **INJECT_GAP = 0:** stay in `IDLE`; back-to-back injection is allowed.
- **enable = 0:** no new pop. A flit already registered still appears on `inject`. The gap counter keeps counting down.
- **inject when idle:** `inject_valid` is high for exactly one cycle per flit. `inject` holds its last value while `inject_valid` = 0.
- **Simultaneous push and pop:** allowed at any level.
  - Count is unchanged.
  - When full, a pop frees a slot and `host_ready` rises on the next cycle.
- **Empty FIFO:** a pushed flit is not poppable in the same cycle it is written.
- **Eject path:** `rx_flit` ← `eject` and `rx_valid` ← `eject_valid` every cycle. No buffering and no backpressure; the host must sink `rx_valid` unconditionally.
- **Counters:** `tx_count` increments on each cycle `inject_valid` = 1; `rx_count` on each `eject_valid` = 1. Both wrap 0xFFFFFFFF → 0.

## Timing
- **Reset values:** `host_ready` 0, `inject_valid` 0, `inject` 0, `rx_valid` 0, `rx_flit` 0, `tx_count` 0, `rx_count` 0. FIFO empty, FSM in `IDLE`, gap counter 0.
- **After reset release:** `host_ready` = 1 on the first cycle after `rst` deasserts.
- **Reset mid-operation:** clears FIFO contents and any pending gap. A flit popped in the reset cycle is discarded and `inject_valid` is 0 on the next cycle.
- **Inject latency:** a flit accepted at edge N can first drive `inject_valid` at edge N+2, given an empty FIFO, `IDLE` and `enable` = 1.
- **Eject latency:** `rx_valid` follows `eject_valid` by exactly 1 cycle.
- **Throughput:** at most 1 flit per (INJECT_GAP+1) cycles.

## Structure
- Shared package `node_pkg`: `FLIT_SIZE` = 82, the flit typedef `flit_t`, and the issue FSM state enum. Router, links and this block all import it.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH): single-clock, synchronous active-high reset.
  - Push/pop/full/empty plus a count output of log2(DEPTH)+1 bits.
  - Registered read data valid the cycle after pop.
- The issue FSM, counters and eject registers live in `local_flit_port`.

## Test plan
- **Reset:** hold `rst` 3 cycles mid-traffic → all outputs at reset values, and `host_ready` = 1 one cycle after release.
- **Back-to-back:** INJECT_GAP = 0; push 0x1, 0x2, 0x3 on consecutive cycles → `inject_valid` on 3 consecutive cycles starting 2 cycles after the first push, in order; `tx_count` = 3.
- **Gap spacing:** INJECT_GAP = 2; push 4 flits → `inject_valid` pulses exactly 3 cycles apart; `inject` stable between pulses.
- **Full FIFO:** `enable` = 0; push 8 flits with DEPTH = 8 → `host_ready` = 0 after the 8th. Raise `enable` → `host_ready` returns 1 the cycle after the first pop, and all 8 flits exit in order.
- **Enable toggle:** deassert `enable` mid-burst → no new pops while it is low; resume order preserved, no flit lost or duplicated.
- **Eject and wrap:** drive `eject_valid` on 5 cycles with distinct flits → `rx_flit`/`rx_valid` match one cycle later; `rx_count` = 5. Force `tx_count` to 0xFFFFFFFF, inject one flit → 0.
